// File: rtl/board_renderer.sv
// board_renderer: 640x480@60 VGA scan of the 10x10 game board, drawing grid and per-cell shapes
module board_renderer #(
    parameter int          CELL_PX  = 40,
    parameter int          BOARD_X0 = 120,
    parameter int          BOARD_Y0 = 40,
    parameter logic [11:0] COL_BG   = 12'h000,
    parameter logic [11:0] COL_GRID = 12'hFFF,
    parameter logic [11:0] COL_TRI  = 12'hF00,
    parameter logic [11:0] COL_CIRC = 12'h00F,
    parameter logic [11:0] COL_SQR  = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [6:0]  addr_x,
    input  logic [1:0]  q_a,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [11:0] vga_rgb,
    output logic        frame_start
);
    localparam int OW = $clog2(CELL_PX);
    localparam logic [9:0] BX0 = 10'(BOARD_X0);
    localparam logic [9:0] BX1 = 10'(BOARD_X0 + 10 * CELL_PX);
    localparam logic [9:0] BY0 = 10'(BOARD_Y0);
    localparam logic [9:0] BY1 = 10'(BOARD_Y0 + 10 * CELL_PX);
    localparam logic [OW-1:0] O_LAST = OW'(CELL_PX - 1);
    localparam logic [7:0] HALF = 8'(CELL_PX / 2);
    localparam logic [7:0] EDGE = 8'(CELL_PX - 1);

    logic [9:0]    hcnt, vcnt;
    logic [OW-1:0] ox, oy;
    logic [3:0]    col, row;
    logic          h_last, v_last, h_in, v_in, in_board, visible, hs_raw, vs_raw;

    logic [OW-1:0] ox1, oy1, ox2, oy2;
    logic          inb1, vis1, hs1, vs1, fs1, re1, be1;
    logic          inb2, vis2, hs2, vs2, fs2, re2, be2;

    logic [7:0]    oxw, oyw, ax, ay;
    logic [11:0]   dsq, pix;
    logic          grid, tri_hit, circ_hit, sq_hit;

    assign h_last   = hcnt == 10'd799;
    assign v_last   = vcnt == 10'd524;
    assign h_in     = hcnt >= BX0 && hcnt < BX1;
    assign v_in     = vcnt >= BY0 && vcnt < BY1;
    assign in_board = h_in && v_in;
    assign visible  = hcnt < 10'd640 && vcnt < 10'd480;
    assign hs_raw   = !(hcnt >= 10'd656 && hcnt <= 10'd751);
    assign vs_raw   = !(vcnt >= 10'd490 && vcnt <= 10'd491);

    // Raster counters; both wrap together on the last pixel of the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= h_last ? '0 : hcnt + 10'd1;
            if (h_last) vcnt <= v_last ? '0 : vcnt + 10'd1;
        end
    end

    // Divider-free cell position: offset counters roll into col/row, saturating at the last cell
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ox  <= '0;
            col <= '0;
            oy  <= '0;
            row <= '0;
        end else begin
            if (h_last) begin
                ox  <= '0;
                col <= '0;
            end else if (h_in) begin
                ox <= ox == O_LAST ? '0 : ox + 1'b1;
                if (ox == O_LAST && col != 4'd9) col <= col + 4'd1;
            end
            if (h_last && v_last) begin
                oy  <= '0;
                row <= '0;
            end else if (h_last && v_in) begin
                oy <= oy == O_LAST ? '0 : oy + 1'b1;
                if (oy == O_LAST && row != 4'd9) row <= row + 4'd1;
            end
        end
    end

    // Stage 1: issue the board read and carry pixel context alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_x <= '0;
            {ox1, oy1} <= '0;
            {inb1, vis1, fs1, re1, be1} <= '0;
            {hs1, vs1} <= 2'b11;
        end else begin
            if (in_board) addr_x <= {3'b000, row} * 7'd10 + {3'b000, col};
            ox1  <= ox;
            oy1  <= oy;
            inb1 <= in_board;
            vis1 <= visible;
            hs1  <= hs_raw;
            vs1  <= vs_raw;
            fs1  <= hcnt == 10'd0 && vcnt == 10'd0;
            re1  <= col == 4'd9;
            be1  <= row == 4'd9;
        end
    end

    // Stage 2: context lines up with q_a returned for the stage-1 address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ox2, oy2} <= '0;
            {inb2, vis2, fs2, re2, be2} <= '0;
            {hs2, vs2} <= 2'b11;
        end else begin
            ox2  <= ox1;
            oy2  <= oy1;
            inb2 <= inb1;
            vis2 <= vis1;
            hs2  <= hs1;
            vs2  <= vs1;
            fs2  <= fs1;
            re2  <= re1;
            be2  <= be1;
        end
    end

    assign oxw      = 8'(ox2);
    assign oyw      = 8'(oy2);
    assign ax       = oxw >= HALF ? oxw - HALF : HALF - oxw;
    assign ay       = oyw >= HALF ? oyw - HALF : HALF - oyw;
    assign dsq      = 12'(ax) * 12'(ax) + 12'(ay) * 12'(ay);
    assign grid     = oxw == 8'd0 || oyw == 8'd0 || (re2 && oxw == EDGE) || (be2 && oyw == EDGE);
    assign tri_hit  = oyw >= 8'd6 && oyw <= 8'd33 && ax + ax <= oyw - 8'd6;
    assign circ_hit = dsq >= 12'd144 && dsq <= 12'd196;
    assign sq_hit   = oxw >= 8'd8 && oxw <= 8'd31 && oyw >= 8'd8 && oyw <= 8'd31 &&
                      (oxw <= 8'd10 || oxw >= 8'd29 || oyw <= 8'd10 || oyw >= 8'd29);

    // Shape selection; grid lines win over any cell content
    always_comb begin
        pix = COL_BG;
        pix = grid                       ? COL_GRID :
              (q_a == 2'b01 && tri_hit)  ? COL_TRI  :
              (q_a == 2'b10 && circ_hit) ? COL_CIRC :
              (q_a == 2'b11 && sq_hit)   ? COL_SQR  : COL_BG;
    end

    // Stage 3: pin registers, syncs delayed identically to the colour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_rgb     <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_rgb     <= vis2 ? (inb2 ? pix : COL_BG) : 12'h000;
            vga_hs      <= hs2;
            vga_vs      <= vs2;
            frame_start <= fs2;
        end
    end
endmodule

// File: tb/tb_board_renderer.sv
// tb_board_renderer: scoreboard bench for board_renderer timing, fetch addressing and shape drawing
module tb_board_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  addr_x;
    logic [1:0]  q_a = 2'b00;
    logic        vga_hs, vga_vs, frame_start;
    logic [11:0] vga_rgb;
    logic [1:0]  board [0:99];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int    t;
        int    kind;
        int    v;
        string nm;
    } ev_t;

    ev_t  ev[$];
    ev_t  cur;
    int   fs_q[$], hsf_q[$], hsr_q[$], vsf_q[$], vsr_q[$];
    logic hs_p = 1'b1;
    logic vs_p = 1'b1;

    board_renderer dut (
        .clk(clk),
        .rst(rst),
        .addr_x(addr_x),
        .q_a(q_a),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_rgb(vga_rgb),
        .frame_start(frame_start)
    );

    always #20 clk = ~clk;

    // Cycles since the latest reset release
    always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

    // Controller read port: registered, one cycle after addr_x
    always @(posedge clk) q_a <= addr_x < 7'd100 ? board[addr_x] : 2'b00;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int t, input int kind, input int v, input string nm);
        ev_t e;
        int  i;
        e = '{t, kind, v, nm};
        i = 0;
        while (i < ev.size() && ev[i].t <= t) i++;
        ev.insert(i, e);
    endfunction

    // Pixel (x,y) of the frame starting at cycle 0 reaches the pins 3 cycles after its counter cycle
    function automatic void pix(input int x, input int y, input int v, input string nm);
        push_ev(3 + 800 * y + x, 0, v, nm);
    endfunction

    // Monitor: pops scheduled expectations as the DUT presents them
    always @(negedge clk) begin
        if (!rst) begin
            while (ev.size() > 0 && ev[0].t == cyc) begin
                cur = ev.pop_front();
                chk(cur.nm, cur.kind == 1 ? int'(addr_x) : int'(vga_rgb), cur.v);
            end
            if (hs_p && !vga_hs && hsf_q.size() > 0) chk("hs_fall", cyc, hsf_q.pop_front());
            if (!hs_p && vga_hs && hsr_q.size() > 0) chk("hs_rise", cyc, hsr_q.pop_front());
            if (vs_p && !vga_vs && vsf_q.size() > 0) chk("vs_fall", cyc, vsf_q.pop_front());
            if (!vs_p && vga_vs && vsr_q.size() > 0) chk("vs_rise", cyc, vsr_q.pop_front());
            if (frame_start) begin
                if (fs_q.size() > 0) chk("frame_start", cyc, fs_q.pop_front());
                else chk("frame_start_unexpected", cyc, -1);
            end
        end
        hs_p <= vga_hs;
        vs_p <= vga_vs;
    end

    initial begin
        foreach (board[i]) board[i] = 2'b00;
        board[0]  = 2'b10;
        board[23] = 2'b01;
        board[99] = 2'b11;

        fs_q  = '{3, 420003};
        hsf_q = '{659, 1459, 2259};
        hsr_q = '{755, 1555};
        vsf_q = '{392003};
        vsr_q = '{393603};

        pix(0,   0,   'h000, "bg_origin");
        pix(650, 10,  'h000, "blanking");
        pix(120, 40,  'hFFF, "grid_corner");
        pix(140, 60,  'h000, "circ_center");
        pix(154, 60,  'h00F, "circ_ring");
        pix(260, 126, 'hF00, "tri_apex");
        pix(245, 126, 'h000, "tri_miss");
        pix(255, 136, 'hF00, "tri_edge");
        pix(254, 136, 'h000, "tri_outside");
        pix(518, 205, 'h000, "cell49_empty");
        pix(519, 205, 'hFFF, "grid_right_edge");
        pix(520, 205, 'h000, "right_of_board");
        pix(352, 300, 'h000, "ring_before_change");
        pix(352, 301, 'h00F, "ring_after_change");
        pix(340, 312, 'h00F, "ring_lower");
        pix(487, 407, 'h000, "sqr_corner_miss");
        pix(489, 409, 'h0F0, "sqr_outline");
        pix(500, 420, 'h000, "sqr_inside");
        pix(300, 439, 'hFFF, "grid_bottom_edge");
        pix(300, 440, 'h000, "below_board");
        push_ev(101061, 1, 23, "addr_r2c3");
        push_ev(101401, 1, 29, "addr_hold");
        push_ev(580300, 0, 'hFFF, "grid_pre_reset");

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_rgb", int'(vga_rgb), 0);
        chk("rst_hs", int'(vga_hs), 1);
        chk("rst_vs", int'(vga_vs), 1);
        chk("rst_addr", int'(addr_x), 0);
        chk("rst_fs", int'(frame_start), 0);
        #2 rst = 1'b0;

        while (cyc != 240703) @(negedge clk);
        board[65] = 2'b10;

        while (cyc != 580300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rgb", int'(vga_rgb), 0);
        chk("async_addr", int'(addr_x), 0);
        chk("async_hs", int'(vga_hs), 1);
        chk("async_vs", int'(vga_vs), 1);
        chk("async_fs", int'(frame_start), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        fs_q.push_back(3);
        hsf_q.push_back(659);
        #2 rst = 1'b0;

        while (cyc < 1000) @(negedge clk);
        foreach (ev[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never observed, expected %0h at cycle %0d", ev[i].nm, ev[i].v, ev[i].t);
        end
        foreach (fs_q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_start: no pulse, expected at cycle %0d", fs_q[i]);
        end
        foreach (hsf_q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hs_fall: no edge, expected at cycle %0d", hsf_q[i]);
        end
        foreach (hsr_q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL hs_rise: no edge, expected at cycle %0d", hsr_q[i]);
        end
        foreach (vsf_q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL vs_fall: no edge, expected at cycle %0d", vsf_q[i]);
        end
        foreach (vsr_q[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL vs_rise: no edge, expected at cycle %0d", vsr_q[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
